// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file, NREG x WIDTH, top register is the PC.
// Two registered read ports, one write port, PC increment/load and a per-register
// busy scoreboard for decode stalls. Optional hardwired-zero R0 via R0_ZERO.
// Optional build macro: REGF_BYPASS_EN -- when defined, read ports return the
// addressed register's post-edge data and busy state (same-cycle write-then-read
// needs no stall); when undefined, read ports return the pre-edge state.
module regfile_mp #(
    parameter int WIDTH    = 16,
    parameter int NREG     = 8,
    parameter int PC_STEP  = 2,
    parameter int RESET_PC = 0,
    parameter int R0_ZERO  = 0,
    localparam int AW      = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w_en,
    input  logic [AW-1:0]    write_add,
    input  logic [WIDTH-1:0] write_data,
    input  logic             pc_inc,
    input  logic             pc_load,
    input  logic [WIDTH-1:0] pc_target,
    input  logic             lock_en,
    input  logic [AW-1:0]    lock_add,
    input  logic [AW-1:0]    RA_add,
    input  logic [AW-1:0]    RB_add,
    output logic [WIDTH-1:0] data_a,
    output logic [WIDTH-1:0] data_b,
    output logic             busy_a,
    output logic             busy_b,
    output logic [WIDTH-1:0] address,
    output logic             pc_wrap
);

    localparam int               PC_IDX   = NREG - 1;
    localparam logic [AW-1:0]    PC_ADDR  = AW'(NREG - 1);
    localparam logic [WIDTH-1:0] PC_RESET = WIDTH'(RESET_PC);
    localparam logic [WIDTH:0]   STEP_EXT = (WIDTH + 1)'(PC_STEP);
    localparam bit               ZERO_R0  = (R0_ZERO != 0);

    // Architectural state
    logic [WIDTH-1:0] r_regs [NREG];
    logic [NREG-1:0]  r_busy;
    logic [WIDTH-1:0] r_data_a;
    logic [WIDTH-1:0] r_data_b;
    logic             r_busy_a;
    logic             r_busy_b;
    logic             r_pc_wrap;

    // Next-state and read-path signals
    logic [WIDTH-1:0] w_regs_nxt [NREG];
    logic [NREG-1:0]  w_busy_nxt;
    logic [WIDTH-1:0] w_rd_regs [NREG];
    logic [NREG-1:0]  w_rd_busy;
    logic [WIDTH:0]   w_pc_sum;
    logic             w_pc_wrap_nxt;
    logic             w_gen_wr;
    logic             w_lock_ok;
    logic             w_ra_zero;
    logic             w_rb_zero;

    // Extra MSB catches the carry out of the PC increment.
    assign w_pc_sum = {1'b0, r_regs[PC_IDX]} + STEP_EXT;

    // General-register write: PC writes go through the PC priority chain, and a
    // hardwired R0 silently drops its writes.
    assign w_gen_wr = w_en && (write_add != PC_ADDR) && !(ZERO_R0 && (write_add == '0));

    // Locks on the PC or on a hardwired R0 can never be cleared by a producer, so drop them.
    assign w_lock_ok = lock_en && (lock_add != PC_ADDR) && !(ZERO_R0 && (lock_add == '0));

    assign w_ra_zero = ZERO_R0 && (RA_add == '0);
    assign w_rb_zero = ZERO_R0 && (RB_add == '0);

    // Register-file next state: general write plus PC priority write > load > increment.
    always_comb begin
        w_regs_nxt    = r_regs;
        w_pc_wrap_nxt = 1'b0;
        if (w_gen_wr) begin
            w_regs_nxt[write_add] = write_data;
        end
        if (w_en && (write_add == PC_ADDR)) begin
            w_regs_nxt[PC_IDX] = write_data;
        end else if (pc_load) begin
            w_regs_nxt[PC_IDX] = pc_target;
        end else if (pc_inc) begin
            w_regs_nxt[PC_IDX] = w_pc_sum[WIDTH-1:0];
            w_pc_wrap_nxt      = w_pc_sum[WIDTH];
        end
    end

    // Scoreboard next state: a write clears, a lock sets; lock applied last so the
    // new producer wins when both hit the same register.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_en) begin
            w_busy_nxt[write_add] = 1'b0;
        end
        if (w_lock_ok) begin
            w_busy_nxt[lock_add] = 1'b1;
        end
    end

`ifdef REGF_BYPASS_EN
    // Read ports see the state being written at this edge.
    assign w_rd_regs = w_regs_nxt;
    assign w_rd_busy = w_busy_nxt;
`else
    // Read ports see the state held before this edge.
    assign w_rd_regs = r_regs;
    assign w_rd_busy = r_busy;
`endif

    // State update: synchronous reset dominates every write, lock and PC change.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= (i == PC_IDX) ? PC_RESET : '0;
            end
            r_busy    <= '0;
            r_data_a  <= '0;
            r_data_b  <= '0;
            r_busy_a  <= 1'b0;
            r_busy_b  <= 1'b0;
            r_pc_wrap <= 1'b0;
        end else begin
            r_regs    <= w_regs_nxt;
            r_busy    <= w_busy_nxt;
            r_data_a  <= w_ra_zero ? '0 : w_rd_regs[RA_add];
            r_data_b  <= w_rb_zero ? '0 : w_rd_regs[RB_add];
            r_busy_a  <= w_ra_zero ? 1'b0 : w_rd_busy[RA_add];
            r_busy_b  <= w_rb_zero ? 1'b0 : w_rd_busy[RB_add];
            r_pc_wrap <= w_pc_wrap_nxt;
        end
    end

    assign data_a  = r_data_a;
    assign data_b  = r_data_b;
    assign busy_a  = r_busy_a;
    assign busy_b  = r_busy_b;
    assign address = r_regs[PC_IDX];
    assign pc_wrap = r_pc_wrap;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and random stimulus against two instances
// (R0_ZERO=0 and R0_ZERO=1) with a behavioural model of the register file.
module tb_regfile_mp;

    localparam int W        = 16;
    localparam int N        = 8;
    localparam int AW       = 3;
    localparam int PCI      = N - 1;
    localparam int STEP     = 2;
    localparam int RESET_PC = 0;

    // Clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          w_en;
    logic [AW-1:0] write_add;
    logic [W-1:0]  write_data;
    logic          pc_inc;
    logic          pc_load;
    logic [W-1:0]  pc_target;
    logic          lock_en;
    logic [AW-1:0] lock_add;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;

    logic [W-1:0] data_a  [2];
    logic [W-1:0] data_b  [2];
    logic [W-1:0] address [2];
    logic         busy_a  [2];
    logic         busy_b  [2];
    logic         pc_wrap [2];

    regfile_mp #(.WIDTH(W), .NREG(N), .PC_STEP(STEP), .RESET_PC(RESET_PC), .R0_ZERO(0)) dut (
        .clk(clk), .rst(rst), .w_en(w_en), .write_add(write_add), .write_data(write_data),
        .pc_inc(pc_inc), .pc_load(pc_load), .pc_target(pc_target),
        .lock_en(lock_en), .lock_add(lock_add), .RA_add(ra), .RB_add(rb),
        .data_a(data_a[0]), .data_b(data_b[0]), .busy_a(busy_a[0]), .busy_b(busy_b[0]),
        .address(address[0]), .pc_wrap(pc_wrap[0])
    );

    regfile_mp #(.WIDTH(W), .NREG(N), .PC_STEP(STEP), .RESET_PC(RESET_PC), .R0_ZERO(1)) dut_z (
        .clk(clk), .rst(rst), .w_en(w_en), .write_add(write_add), .write_data(write_data),
        .pc_inc(pc_inc), .pc_load(pc_load), .pc_target(pc_target),
        .lock_en(lock_en), .lock_add(lock_add), .RA_add(ra), .RB_add(rb),
        .data_a(data_a[1]), .data_b(data_b[1]), .busy_a(busy_a[1]), .busy_b(busy_b[1]),
        .address(address[1]), .pc_wrap(pc_wrap[1])
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: index 0 = plain R0, index 1 = hardwired R0
    int m_reg  [2][N];
    bit m_busy [2][N];
    int e_da   [2];
    int e_db   [2];
    int e_addr [2];
    bit e_ba   [2];
    bit e_bb   [2];
    bit e_wrap [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the model by one edge using the inputs currently driven.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int pre_reg  [N];
            bit pre_busy [N];
            int src_reg  [N];
            bit src_busy [N];
            bool_blk: begin
                if (rst) begin
                    for (int i = 0; i < N; i++) begin
                        m_reg[k][i]  = (i == PCI) ? RESET_PC : 0;
                        m_busy[k][i] = 1'b0;
                    end
                    e_da[k] = 0; e_db[k] = 0; e_ba[k] = 0; e_bb[k] = 0; e_wrap[k] = 0;
                    e_addr[k] = RESET_PC;
                end else begin
                    pre_reg   = m_reg[k];
                    pre_busy  = m_busy[k];
                    e_wrap[k] = 1'b0;
                    if (w_en && int'(write_add) == PCI) begin
                        m_reg[k][PCI] = int'(write_data);
                    end else if (pc_load) begin
                        m_reg[k][PCI] = int'(pc_target);
                    end else if (pc_inc) begin
                        int s;
                        s = m_reg[k][PCI] + STEP;
                        e_wrap[k]     = (s >= (1 << W));
                        m_reg[k][PCI] = s % (1 << W);
                    end
                    if (w_en && int'(write_add) != PCI && !(k == 1 && write_add == 0))
                        m_reg[k][write_add] = int'(write_data);
                    if (w_en)
                        m_busy[k][write_add] = 1'b0;
                    if (lock_en && int'(lock_add) != PCI && !(k == 1 && lock_add == 0))
                        m_busy[k][lock_add] = 1'b1;
`ifdef REGF_BYPASS_EN
                    src_reg  = m_reg[k];
                    src_busy = m_busy[k];
`else
                    src_reg  = pre_reg;
                    src_busy = pre_busy;
`endif
                    e_da[k]   = (k == 1 && ra == 0) ? 0 : src_reg[ra];
                    e_db[k]   = (k == 1 && rb == 0) ? 0 : src_reg[rb];
                    e_ba[k]   = (k == 1 && ra == 0) ? 1'b0 : src_busy[ra];
                    e_bb[k]   = (k == 1 && rb == 0) ? 1'b0 : src_busy[rb];
                    e_addr[k] = m_reg[k][PCI];
                end
            end
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("data_a[%0d]", k),  32'(data_a[k]),  32'(e_da[k]));
            check($sformatf("data_b[%0d]", k),  32'(data_b[k]),  32'(e_db[k]));
            check($sformatf("busy_a[%0d]", k),  32'(busy_a[k]),  32'(e_ba[k]));
            check($sformatf("busy_b[%0d]", k),  32'(busy_b[k]),  32'(e_bb[k]));
            check($sformatf("address[%0d]", k), 32'(address[k]), 32'(e_addr[k]));
            check($sformatf("pc_wrap[%0d]", k), 32'(pc_wrap[k]), 32'(e_wrap[k]));
        end
    endtask

    // Driver tasks
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        rst        = 1'b0;
        w_en       = 1'b0;
        write_add  = '0;
        write_data = '0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        pc_target  = '0;
        lock_en    = 1'b0;
        lock_add   = '0;
    endtask

    initial begin
        idle();
        ra  = '0;
        rb  = '0;
        rst = 1'b1;
        step();
        step();

        // Read every index after reset
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            ra = AW'(i);
            rb = AW'(N - 1 - i);
            step();
            check("rst_data_a", 32'(data_a[0]), (i == PCI) ? 32'(RESET_PC) : 32'h0);
            check("rst_busy_a", 32'(busy_a[0]), 32'h0);
            check("rst_wrap",   32'(pc_wrap[0]), 32'h0);
        end

        // PC increment wrapping past 16'hFFFF
        idle(); w_en = 1'b1; write_add = AW'(PCI); write_data = 16'hFFFE;
        step();
        check("pc_write", 32'(address[0]), 32'h0000_FFFE);
        idle(); pc_inc = 1'b1;
        step();
        check("wrap_addr",  32'(address[0]), 32'h0);
        check("wrap_pulse", 32'(pc_wrap[0]), 32'h1);
        idle();
        step();
        check("wrap_clear", 32'(pc_wrap[0]), 32'h0);

        // PC priority: write beats load beats increment
        idle(); w_en = 1'b1; write_add = AW'(PCI); write_data = 16'h0100;
        pc_load = 1'b1; pc_target = 16'h0200; pc_inc = 1'b1;
        step();
        check("prio_write", 32'(address[0]), 32'h0100);
        check("prio_nowrap", 32'(pc_wrap[0]), 32'h0);
        idle(); pc_load = 1'b1; pc_target = 16'h0200; pc_inc = 1'b1;
        step();
        check("prio_load", 32'(address[0]), 32'h0200);

        // Lock R3, then clear it with a write while reading it
        idle(); w_en = 1'b1; write_add = 3'd3; write_data = 16'h1111; ra = 3'd3;
        step();
        idle(); lock_en = 1'b1; lock_add = 3'd3; ra = 3'd3;
        step();
`ifdef REGF_BYPASS_EN
        check("lock_busy", 32'(busy_a[0]), 32'h1);
`else
        check("lock_busy", 32'(busy_a[0]), 32'h0);
`endif
        idle(); w_en = 1'b1; write_add = 3'd3; write_data = 16'hABCD; ra = 3'd3;
        step();
`ifdef REGF_BYPASS_EN
        check("wr_data_a", 32'(data_a[0]), 32'hABCD);
        check("wr_busy_a", 32'(busy_a[0]), 32'h0);
`else
        check("wr_data_a", 32'(data_a[0]), 32'h1111);
        check("wr_busy_a", 32'(busy_a[0]), 32'h1);
`endif
        idle(); ra = 3'd3;
        step();
        check("after_data_a", 32'(data_a[0]), 32'hABCD);
        check("after_busy_a", 32'(busy_a[0]), 32'h0);

        // Write and lock R0 in the same cycle, then read it on both ports
        idle(); w_en = 1'b1; write_add = 3'd0; write_data = 16'h1234;
        lock_en = 1'b1; lock_add = 3'd0; ra = 3'd0; rb = 3'd0;
        step();
        idle(); ra = 3'd0; rb = 3'd0;
        step();
        check("r0z_data",  32'(data_a[1]), 32'h0);
        check("r0z_busy",  32'(busy_b[1]), 32'h0);
        check("r0_data",   32'(data_b[0]), 32'h1234);
        check("r0_busy",   32'(busy_a[0]), 32'h1);

        // Lock of the PC index is ignored
        idle(); lock_en = 1'b1; lock_add = AW'(PCI); ra = AW'(PCI);
        step();
        idle(); ra = AW'(PCI);
        step();
        check("pc_lock_ignored", 32'(busy_a[0]), 32'h0);

        // Random traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            rst        = ($urandom_range(0, 39) == 0);
            w_en       = $urandom_range(0, 1);
            write_add  = AW'($urandom_range(0, N - 1));
            write_data = ($urandom_range(0, 3) == 0) ? (16'hFFF0 | W'($urandom_range(0, 15)))
                                                     : W'($urandom);
            pc_inc     = $urandom_range(0, 1);
            pc_load    = ($urandom_range(0, 7) == 0);
            pc_target  = W'($urandom);
            lock_en    = ($urandom_range(0, 2) == 0);
            lock_add   = AW'($urandom_range(0, N - 1));
            ra         = AW'($urandom_range(0, N - 1));
            rb         = ($urandom_range(0, 3) == 0) ? ra : AW'($urandom_range(0, N - 1));
            step();
        end

        // Pending activity, then reset wins at the same edge
        idle(); w_en = 1'b1; write_add = 3'd5; write_data = 16'h5555;
        lock_en = 1'b1; lock_add = 3'd2; pc_inc = 1'b1;
        step();
        w_en = 1'b1; write_add = AW'(PCI); write_data = 16'hFFFE; lock_en = 1'b1; lock_add = 3'd5;
        pc_load = 1'b1; pc_target = 16'h7777; rst = 1'b1;
        step();
        check("rst_mid_addr", 32'(address[0]), 32'(RESET_PC));
        check("rst_mid_wrap", 32'(pc_wrap[0]), 32'h0);
        idle();
        for (int i = 0; i < N; i++) begin
            ra = AW'(i);
            rb = AW'(i);
            step();
            check("post_rst_data", 32'(data_a[0]), (i == PCI) ? 32'(RESET_PC) : 32'h0);
            check("post_rst_busy", 32'(busy_b[0]), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
